// File: rtl/i2c_master_read_n.sv
// I2C read master: one complete read transaction per rising edge of Go.
// The transaction is START, the address byte {SlaveAddress, R}, the slave's
// address ACK, NumBytes data bytes read MSB-first, and then STOP. The master
// ACKs every data byte except the last one, which it NACKs.
// Each bit slot is four quarters of Q clocks. SCL is low in q0/q1 and high in
// q2/q3. SDA only changes at the start of q0 and is sampled at the start of q3.
// SCL and the SDA pull-down are registered. They are derived from the *next*
// sequencer state, so the pins change on the same edge as the sequencer.
module i2c_master_read_n #(
  parameter int unsigned ClockFrequency = 60000000,
  parameter int unsigned BaudRate       = 30000,
  parameter logic [6:0]  SlaveAddress   = 7'b1001000,
  parameter int unsigned NumBytes       = 2
) (
  input  logic                    clock,
  input  logic                    Reset,
  input  logic                    Go,
  output logic                    SCL,
  inout  wire                     SDA,
  output logic [8*NumBytes-1:0]   ReadData,
  output logic                    Busy,
  output logic                    Done,
  output logic                    AckError
);

  localparam int unsigned Q  = ClockFrequency / (4 * BaudRate);
  localparam int unsigned QW = (Q > 2) ? $clog2(Q) : 1;
  localparam int unsigned DW = 8 * NumBytes;
  localparam logic [QW-1:0] QLast    = QW'(Q - 1);
  localparam logic [1:0]    LastByte = 2'(NumBytes - 1);
  localparam logic [7:0]    AddrWord = {SlaveAddress, 1'b1};

  typedef enum logic [2:0] {
    IDLE,
    START,
    ADDR,
    AACK,
    READ,
    MACK,
    STOP
  } state_t;

  state_t          state_q, state_d;
  logic [QW-1:0]   qcnt_q, qcnt_d;        // clocks within the current quarter
  logic [1:0]      quarter_q, quarter_d;  // quarter within the current bit slot
  logic [2:0]      bit_q, bit_d;          // bit slot within a byte
  logic [1:0]      byte_q, byte_d;        // data byte being read
  logic [DW-1:0]   shadow_q, shadow_d;    // bits being collected from the bus
  logic [DW-1:0]   read_data_q, read_data_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            ack_err_q, ack_err_d;
  logic            ack_bit_q, ack_bit_d;  // SDA level seen during the address ACK slot
  logic            scl_q, scl_d;
  logic            sda_low_q, sda_low_d;  // 1 = pull SDA low, 0 = release
  logic            go_s_q, go_s_d;
  logic            go_prev_q, go_prev_d;
  logic            go_rise_q, go_rise_d;
  logic            sda_s1_q, sda_s1_d;
  logic            sda_s2_q, sda_s2_d;
  logic [7:0]      addr_word;

  assign addr_word = AddrWord;

  // Sequencer: quarter timing, state transitions, sampling and result capture.
  always_comb begin
    state_d     = state_q;
    qcnt_d      = qcnt_q;
    quarter_d   = quarter_q;
    bit_d       = bit_q;
    byte_d      = byte_q;
    shadow_d    = shadow_q;
    read_data_d = read_data_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    ack_err_d   = ack_err_q;
    ack_bit_d   = ack_bit_q;
    go_s_d      = Go;
    go_prev_d   = go_s_q;
    go_rise_d   = go_s_q & ~go_prev_q;
    sda_s1_d    = SDA;
    sda_s2_d    = sda_s1_q;

    if (state_q == IDLE) begin
      if (go_rise_q) begin
        state_d   = START;
        qcnt_d    = '0;
        quarter_d = 2'd0;
        bit_d     = 3'd0;
        byte_d    = 2'd0;
        busy_d    = 1'b1;
        ack_err_d = 1'b0;
      end
    end else if (qcnt_q != QLast) begin
      qcnt_d = qcnt_q + 1'b1;
    end else begin
      qcnt_d    = '0;
      quarter_d = quarter_q + 2'd1;

      // End of q2 is the start of q3: SCL has been high long enough to sample.
      if (quarter_q == 2'd2) begin
        if (state_q == READ) begin
          shadow_d = {shadow_q[DW-2:0], sda_s2_q};
        end
        if (state_q == AACK) begin
          ack_bit_d = sda_s2_q;
        end
      end

      // End of q3 closes the bit slot.
      if (quarter_q == 2'd3) begin
        case (state_q)
          START: begin
            state_d = ADDR;
            bit_d   = 3'd0;
          end
          ADDR: begin
            if (bit_q == 3'd7) begin
              state_d = AACK;
            end
            bit_d = bit_q + 3'd1;
          end
          AACK: begin
            if (ack_bit_q) begin
              ack_err_d = 1'b1;
              state_d   = STOP;
            end else begin
              state_d = READ;
              bit_d   = 3'd0;
              byte_d  = 2'd0;
            end
          end
          READ: begin
            if (bit_q == 3'd7) begin
              state_d = MACK;
            end
            bit_d = bit_q + 3'd1;
          end
          MACK: begin
            if (byte_q == LastByte) begin
              state_d = STOP;
            end else begin
              state_d = READ;
              bit_d   = 3'd0;
              byte_d  = byte_q + 2'd1;
            end
          end
          STOP: begin
            state_d = IDLE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            if (!ack_err_q) begin
              read_data_d = shadow_q;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    end
  end

  // Bus pin levels for the slot position the sequencer is about to enter.
  always_comb begin
    scl_d     = 1'b1;
    sda_low_d = 1'b0;
    case (state_d)
      START: begin
        scl_d     = (quarter_d != 2'd3);
        sda_low_d = quarter_d[1];
      end
      ADDR: begin
        scl_d     = quarter_d[1];
        sda_low_d = ~addr_word[3'd7 - bit_d];
      end
      AACK, READ: begin
        scl_d = quarter_d[1];
      end
      MACK: begin
        scl_d     = quarter_d[1];
        sda_low_d = (byte_d != LastByte);
      end
      STOP: begin
        scl_d     = quarter_d[1];
        sda_low_d = (quarter_d != 2'd3);
      end
      default: begin
        scl_d     = 1'b1;
        sda_low_d = 1'b0;
      end
    endcase
  end

  // State register; reset drops the bus to idle at once, without a STOP.
  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      state_q     <= IDLE;
      qcnt_q      <= '0;
      quarter_q   <= 2'd0;
      bit_q       <= 3'd0;
      byte_q      <= 2'd0;
      shadow_q    <= '0;
      read_data_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ack_err_q   <= 1'b0;
      ack_bit_q   <= 1'b0;
      scl_q       <= 1'b1;
      sda_low_q   <= 1'b0;
      go_s_q      <= 1'b0;
      go_prev_q   <= 1'b0;
      go_rise_q   <= 1'b0;
      sda_s1_q    <= 1'b1;
      sda_s2_q    <= 1'b1;
    end else begin
      state_q     <= state_d;
      qcnt_q      <= qcnt_d;
      quarter_q   <= quarter_d;
      bit_q       <= bit_d;
      byte_q      <= byte_d;
      shadow_q    <= shadow_d;
      read_data_q <= read_data_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ack_err_q   <= ack_err_d;
      ack_bit_q   <= ack_bit_d;
      scl_q       <= scl_d;
      sda_low_q   <= sda_low_d;
      go_s_q      <= go_s_d;
      go_prev_q   <= go_prev_d;
      go_rise_q   <= go_rise_d;
      sda_s1_q    <= sda_s1_d;
      sda_s2_q    <= sda_s2_d;
    end
  end

  assign SDA      = sda_low_q ? 1'b0 : 1'bz;
  assign SCL      = scl_q;
  assign ReadData = read_data_q;
  assign Busy     = busy_q;
  assign Done     = done_q;
  assign AckError = ack_err_q;

endmodule

// File: tb/tb_i2c_master_read_n.sv
// Bench for i2c_master_read_n.
// Two instances (2-byte and 1-byte reads) share the clock and the reset.
// Each instance has its own pulled-up SDA and a behavioural TMP101-style slave.
module tb_i2c_master_read_n;

  localparam int CF = 400;
  localparam int BR = 25;
  localparam int QQ = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic [1:0] go_v, present_v;
  logic [1:0] scl_v, sda_v, busy_v, done_v, err_v;
  logic [1:0][31:0] rd_v;
  logic [1:0][3:0][7:0] sdata_v;
  logic [1:0][15:0] start_v, stop_v, mack_v, mnack_v;
  logic [1:0][7:0] addr_v;
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] model_rd [2];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int NB = (gi == 0) ? 2 : 1;
    localparam int P_IDLE = 0, P_ADDR = 1, P_AACK = 2, P_DATA = 3, P_MACK = 4;
    wire sda;
    logic scl, busy, done, ack_err;
    logic [8*NB-1:0] rdata;
    logic drive_low = 1'b0;
    logic scl_p = 1'b1, sda_p = 1'b1, mack_bit = 1'b1;
    int phase = 0, bitn = 0, bidx = 0;
    logic [7:0] addr = 8'h00;
    logic [15:0] starts = 16'd0, stops = 16'd0, macks = 16'd0, mnacks = 16'd0;

    pullup (sda);
    assign sda = (drive_low && rst_n) ? 1'b0 : 1'bz;

    i2c_master_read_n #(
      .ClockFrequency(CF),
      .BaudRate(BR),
      .SlaveAddress(7'b1001000),
      .NumBytes(NB)
    ) u_dut (
      .clock(clk),
      .Reset(rst_n),
      .Go(go_v[gi]),
      .SCL(scl),
      .SDA(sda),
      .ReadData(rdata),
      .Busy(busy),
      .Done(done),
      .AckError(ack_err)
    );

    assign scl_v[gi]   = scl;
    assign sda_v[gi]   = sda;
    assign busy_v[gi]  = busy;
    assign done_v[gi]  = done;
    assign err_v[gi]   = ack_err;
    assign rd_v[gi]    = 32'(rdata);
    assign start_v[gi] = starts;
    assign stop_v[gi]  = stops;
    assign mack_v[gi]  = macks;
    assign mnack_v[gi] = mnacks;
    assign addr_v[gi]  = addr;

    // Oversampling slave: detects START/STOP and SCL edges, and answers reads.
    always @(posedge clk) begin
      scl_p <= scl;
      sda_p <= sda;
      if (!rst_n) begin
        drive_low <= 1'b0;
        phase     <= P_IDLE;
      end else if (scl_p && !scl) begin
        case (phase)
          P_ADDR: if (bitn == 8) begin
            if (present_v[gi] && addr == 8'h91) begin
              drive_low <= 1'b1;
              phase     <= P_AACK;
            end else begin
              phase <= P_IDLE;
            end
          end
          P_AACK: begin
            drive_low <= ~sdata_v[gi][0][7];
            phase     <= P_DATA;
            bitn      <= 1;
            bidx      <= 0;
          end
          P_DATA: if (bitn == 8) begin
            drive_low <= 1'b0;
            phase     <= P_MACK;
          end else begin
            drive_low <= ~sdata_v[gi][bidx][7-bitn];
            bitn      <= bitn + 1;
          end
          P_MACK: if (!mack_bit) begin
            drive_low <= ~sdata_v[gi][bidx+1][7];
            bidx      <= bidx + 1;
            bitn      <= 1;
            phase     <= P_DATA;
          end else begin
            phase <= P_IDLE;
          end
          default: ;
        endcase
      end else if (!scl_p && scl) begin
        if (phase == P_ADDR) begin
          addr <= {addr[6:0], sda};
          bitn <= bitn + 1;
        end else if (phase == P_MACK) begin
          mack_bit <= sda;
          if (sda) mnacks <= mnacks + 16'd1;
          else     macks  <= macks + 16'd1;
        end
      end else if (scl_p && scl && sda_p && !sda) begin
        phase     <= P_ADDR;
        bitn      <= 0;
        drive_low <= 1'b0;
        starts    <= starts + 16'd1;
      end else if (scl_p && scl && !sda_p && sda) begin
        phase     <= P_IDLE;
        drive_low <= 1'b0;
        stops     <= stops + 16'd1;
      end
    end
  end

  typedef struct {
    int          idx;
    logic        present;
    logic [31:0] bytes;    // byte 0 in bits 31:24
    int          mode;     // 0 pulse, 1 hold Go high, 2 extra Go pulse while busy
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // The expected word is the returned bytes in arrival order, first byte on top.
  function automatic logic [31:0] model_word(input logic [31:0] bytes, input int nb);
    logic [31:0] w;
    w = 32'd0;
    for (int b = 0; b < nb; b++) w = (w << 8) | 32'(bytes[31-8*b -: 8]);
    return w;
  endfunction

  // The latency counts bit slots: START, 8 address, ACK, 9 per byte when ACKed, STOP.
  function automatic int model_latency(input logic present, input int nb);
    int slots;
    slots = 1 + 8 + 1 + 1;
    if (present) slots += 9 * nb;
    return slots * 4 * QQ + 2;
  endfunction

  task automatic run_read(input int idx, input logic present, input logic [31:0] bytes,
                          input int mode, input logic [31:0] want_rd, input logic want_err,
                          input int want_lat);
    int nb, n;
    bit seen;
    logic [15:0] s0, p0, a0, k0;
    nb = (idx == 0) ? 2 : 1;
    go_v[idx] = 1'b0;
    present_v[idx] = present;
    for (int b = 0; b < 4; b++) sdata_v[idx][b] = bytes[31-8*b -: 8];
    repeat (4) @(negedge clk);
    s0 = start_v[idx]; p0 = stop_v[idx]; a0 = mack_v[idx]; k0 = mnack_v[idx];
    go_v[idx] = 1'b1;
    @(posedge clk);
    n = 0;
    seen = 0;
    while (!seen && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      if (mode != 1 && n == 3) go_v[idx] = 1'b0;
      if (mode == 2 && n == 60) go_v[idx] = 1'b1;
      if (mode == 2 && n == 64) go_v[idx] = 1'b0;
      if (n == 20) check("busy_mid", 32'(busy_v[idx]), 32'd1);
      if (done_v[idx]) seen = 1;
    end
    check("latency", n, want_lat);
    check("busy_at_done", 32'(busy_v[idx]), 32'd0);
    check("readdata", rd_v[idx], want_rd);
    check("ackerror", 32'(err_v[idx]), 32'(want_err));
    @(posedge clk);
    #1;
    check("done_width", 32'(done_v[idx]), 32'd0);
    repeat (100) @(posedge clk);
    #1;
    check("starts", 32'(start_v[idx] - s0), 32'd1);
    check("stops", 32'(stop_v[idx] - p0), 32'd1);
    check("addr_byte", 32'(addr_v[idx]), 32'h91);
    check("master_acks", 32'(mack_v[idx] - a0), present ? 32'(nb - 1) : 32'd0);
    check("master_nacks", 32'(mnack_v[idx] - k0), present ? 32'd1 : 32'd0);
    check("busy_idle", 32'(busy_v[idx]), 32'd0);
    go_v[idx] = 1'b0;
    model_rd[idx] = want_rd;
    $display("txn inst=%0d present=%0d mode=%0d rd=%0h err=%0d latency=%0d",
             idx, present, mode, rd_v[idx], err_v[idx], n);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, mode, nb;
    logic present;
    logic [31:0] bytes, w;
    logic [15:0] p0;

    rst_n = 1'b0;
    go_v = 2'b11;
    present_v = 2'b00;
    sdata_v = '0;
    model_rd[0] = 32'd0;
    model_rd[1] = 32'd0;

    vecs[0] = '{0, 1'b1, 32'h19600000, 0, 32'h1960, 1'b0, 466};
    vecs[1] = '{0, 1'b0, 32'hA5A50000, 0, 32'h1960, 1'b1, 178};
    vecs[2] = '{0, 1'b1, 32'h19600000, 1, 32'h1960, 1'b0, 466};
    vecs[3] = '{0, 1'b1, 32'h3C5A0000, 2, 32'h3C5A, 1'b0, 466};
    vecs[4] = '{1, 1'b1, 32'h19000000, 0, 32'h0019, 1'b0, 322};
    vecs[5] = '{1, 1'b0, 32'h77000000, 0, 32'h0019, 1'b1, 178};

    // Reset with Go held high: the bus stays idle.
    repeat (6) @(negedge clk);
    check("rst_scl", 32'(scl_v[0]), 32'd1);
    check("rst_sda", 32'(sda_v[0]), 32'd1);
    check("rst_busy", 32'(busy_v[0]), 32'd0);
    check("rst_done", 32'(done_v[0]), 32'd0);
    check("rst_err", 32'(err_v[0]), 32'd0);
    check("rst_rd", rd_v[0], 32'd0);
    check("rst_starts", 32'(start_v[0]), 32'd0);
    go_v = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++)
      run_read(vecs[i].idx, vecs[i].present, vecs[i].bytes, vecs[i].mode,
               vecs[i].exp_rd, vecs[i].exp_err, vecs[i].exp_lat);

    // Reset during the first data byte, bit slot 4, while SCL is low.
    present_v[0] = 1'b1;
    sdata_v[0][0] = 8'hC3;
    sdata_v[0][1] = 8'h7E;
    repeat (4) @(negedge clk);
    p0 = stop_v[0];
    go_v[0] = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 232; k++) begin
      @(posedge clk);
      #1;
      if (k == 3) go_v[0] = 1'b0;
    end
    check("pre_rst_scl", 32'(scl_v[0]), 32'd0);
    check("pre_rst_busy", 32'(busy_v[0]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_scl", 32'(scl_v[0]), 32'd1);
    check("async_sda", 32'(sda_v[0]), 32'd1);
    check("async_busy", 32'(busy_v[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("abort_no_stop", 32'(stop_v[0] - p0), 32'd0);
    check("abort_rd0", rd_v[0], 32'd0);
    check("abort_rd1", rd_v[1], 32'd0);
    $display("txn inst=0 reset during read, scl=%0d busy=%0d", scl_v[0], busy_v[0]);
    model_rd[0] = 32'd0;
    model_rd[1] = 32'd0;
    run_read(0, 1'b1, 32'h19600000, 0, 32'h1960, 1'b0, 466);

    // Randomized reads checked against the byte-level model.
    for (int r = 0; r < 10; r++) begin
      idx = int'($urandom_range(0, 1));
      present = ($urandom_range(0, 3) != 0);
      bytes = $urandom;
      mode = int'($urandom_range(0, 2));
      nb = (idx == 0) ? 2 : 1;
      w = present ? model_word(bytes, nb) : model_rd[idx];
      run_read(idx, present, bytes, mode, w, ~present, model_latency(present, nb));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
